// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Purpose  : Shared types and helpers for the decoder_scan block: FSM state
//             encoding, mode constants and the one-hot helper function.
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decode supported by the helper (SEL_W up to 8). Callers
    // narrow the result to their own OUT_W with a size cast.
    localparam int ONEHOT_MAX_W = 256;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] index);
        logic [ONEHOT_MAX_W-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_counter
//  Purpose  : Counts 0..DWELL-1 and flags the terminal count, then restarts.
//             A synchronous clear holds the count at zero.
//  Ports    : clk, rst    - clock / synchronous active-high reset
//             clear       - force count to zero on the next edge
//             tc          - high while count == DWELL-1
//  Revision : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int               CNT_W  = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_count;

    assign tc = (r_count == C_LAST);

    // Wrapping at C_LAST keeps the count inside 0..DWELL-1 at all times.
    always_ff @(posedge clk) begin
        if (rst || clear || tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_scan
//  Purpose  : Registered SEL_W -> 2**SEL_W one-hot decoder. DIRECT mode
//             decodes a qualified select; SCAN mode walks one hot bit across
//             all outputs, holding each for DWELL cycles.
//  Ports    : clk, rst          - clock / synchronous active-high reset
//             en, mode          - enable, 0 = DIRECT / 1 = SCAN
//             sel_valid, sel    - DIRECT-mode select and qualifier
//             y, y_valid        - registered one-hot output and its flag
//             idx               - index currently driven hot
//             wrap              - one-cycle pulse on SCAN index wrap to 0
//  Options  : DECODER_SCAN_BLANK_EN - blank y on the first cycle of every
//             SCAN dwell period (requires DWELL >= 2).
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 2,
    parameter  int DWELL = 4,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

`ifdef DECODER_SCAN_BLANK_EN
    localparam logic C_BLANK = 1'b1;
`else
    localparam logic C_BLANK = 1'b0;
`endif

    generate
        if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
            $error("decoder_scan: DWELL must be within 1..65535");
        end
        if (C_BLANK && DWELL < 2) begin : g_bad_blank
            $error("decoder_scan: blanking requires DWELL >= 2");
        end
        if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
            $error("decoder_scan: SEL_W must be within 1..8");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [OUT_W-1:0] r_y,   w_y_next;
    logic             r_v,   w_v_next;
    logic [SEL_W-1:0] r_idx, w_idx_next;
    logic             r_wrap, w_wrap_next;
    logic [SEL_W-1:0] w_idx_inc;
    logic             w_tc;
    logic             w_cnt_clear;

    assign w_idx_inc = r_idx + SEL_W'(1);

    // The counter only runs while the block stays in SCAN; any entry or
    // exit discards an in-flight dwell count.
    assign w_cnt_clear = (w_state_next != SCAN) || (r_state != SCAN);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (w_cnt_clear),
        .tc    (w_tc)
    );

    // Next state depends only on en/mode: en=0 wins, then the mode picks
    // the working state. A state change is what marks an entry edge.
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = IDLE;
        end else if (mode == MODE_SCAN) begin
            w_state_next = SCAN;
        end else begin
            w_state_next = DIRECT;
        end
    end

    always_comb begin
        w_y_next    = r_y;
        w_v_next    = r_v;
        w_idx_next  = r_idx;
        w_wrap_next = 1'b0;
        case (w_state_next)
            IDLE: begin
                w_y_next = '0;
                w_v_next = 1'b0;
            end
            DIRECT: begin
                if (r_state != DIRECT) begin
                    w_y_next = '0;
                    w_v_next = 1'b0;
                end else if (sel_valid) begin
                    w_y_next   = OUT_W'(onehot(8'(sel)));
                    w_idx_next = sel;
                    w_v_next   = 1'b1;
                end
            end
            SCAN: begin
                w_v_next = 1'b1;
                if (r_state != SCAN) begin
                    w_idx_next = '0;
                    w_y_next   = C_BLANK ? '0 : OUT_W'(1);
                end else if (w_tc) begin
                    w_idx_next  = w_idx_inc;
                    w_y_next    = C_BLANK ? '0 : OUT_W'(onehot(8'(w_idx_inc)));
                    w_wrap_next = (r_idx == {SEL_W{1'b1}});
                end else begin
                    // Re-asserting the current bit also ends a blanked cycle.
                    w_y_next = OUT_W'(onehot(8'(r_idx)));
                end
            end
            default: begin
                w_y_next = '0;
                w_v_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_v     <= 1'b0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_y     <= w_y_next;
            r_v     <= w_v_next;
            r_idx   <= w_idx_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign y       = r_y;
    assign y_valid = r_v;
    assign idx     = r_idx;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire
